// File: rtl/tnn_feature_packer_if.sv
// Stream bundle between the raw-sample source, the feature packer and the classifier inputs.
// The packer takes the slave modport; the source/sink side takes the master modport.
interface tnn_feature_packer_if #(
    parameter int unsigned RAW_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [RAW_W-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [1:0]       input_a;
    logic [1:0]       input_b;
    logic [1:0]       input_c;
    logic [1:0]       input_d;
    logic [1:0]       input_e;
    logic [1:0]       input_f;
    logic [1:0]       input_g;
    logic             frame_err;
    logic [CNT_W-1:0] vec_cnt;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, input_a, input_b, input_c, input_d, input_e, input_f,
        input  input_g, frame_err, vec_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, input_a, input_b, input_c, input_d, input_e, input_f,
        output input_g, frame_err, vec_cnt
    );
endinterface

// File: rtl/tnn_feature_packer.sv
// Quantises raw feature samples to 2-bit codes against three thresholds and packs seven
// of them into one vector for the combinational TNN classifier, with framing checks.
module tnn_feature_packer #(
    parameter int unsigned RAW_W = 8,
    parameter int unsigned T0    = 64,
    parameter int unsigned T1    = 128,
    parameter int unsigned T2    = 192,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    tnn_feature_packer_if.slave bus
);
    localparam logic [RAW_W-1:0] TH0 = RAW_W'(T0);
    localparam logic [RAW_W-1:0] TH1 = RAW_W'(T1);
    localparam logic [RAW_W-1:0] TH2 = RAW_W'(T2);

    typedef enum logic [1:0] {StCollect, StHold, StDiscard} state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       shadow_q [6];
    logic [1:0]       shadow_d [6];
    logic [13:0]      vec_q, vec_d;
    logic             discard_q, discard_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             s_ready;
    logic             accept;
    logic [1:0]       code;

    always_comb begin
        if (bus.s_data >= TH2)      code = 2'd3;
        else if (bus.s_data >= TH1) code = 2'd2;
        else if (bus.s_data >= TH0) code = 2'd1;
        else                        code = 2'd0;
    end

    // rdy_en_q keeps the stream closed for the first cycle after reset release.
    assign s_ready = rdy_en_q && (state_q != StHold);
    assign accept  = bus.s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        vec_d       = vec_q;
        discard_d   = discard_q;
        frame_err_d = 1'b0;
        cnt_d       = cnt_q;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (idx_q == 3'd6) begin
                        vec_d       = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3],
                                       shadow_q[4], shadow_q[5], code};
                        state_d     = StHold;
                        discard_d   = !bus.s_last;
                        frame_err_d = !bus.s_last;
                        idx_d       = 3'd0;
                    end else if (bus.s_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = 3'd0;
                    end else begin
                        shadow_d[idx_q] = code;
                        idx_d           = idx_q + 3'd1;
                    end
                end
            end
            StHold: begin
                if (bus.m_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = discard_q ? StDiscard : StCollect;
                end
            end
            StDiscard: begin
                if (accept && bus.s_last) begin
                    state_d = StCollect;
                    idx_d   = 3'd0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            idx_q       <= 3'd0;
            for (int i = 0; i < 6; i++) shadow_q[i] <= 2'd0;
            vec_q       <= '0;
            discard_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            vec_q       <= vec_d;
            discard_q   <= discard_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = (state_q == StHold);
    assign bus.input_a   = vec_q[13:12];
    assign bus.input_b   = vec_q[11:10];
    assign bus.input_c   = vec_q[9:8];
    assign bus.input_d   = vec_q[7:6];
    assign bus.input_e   = vec_q[5:4];
    assign bus.input_f   = vec_q[3:2];
    assign bus.input_g   = vec_q[1:0];
    assign bus.frame_err = frame_err_q;
    assign bus.vec_cnt   = cnt_q;
endmodule
